fetch_decode: RTL and testbench
===============================

# fetch_decode

Sequencer and decode stage directly upstream of the execute stage of the video display processor's control core. It fetches 16-bit instruction words from program memory through a request/valid handshake and decodes them. It reads a 16×16 register file, drives `exe_a`, `exe_b` and `exe_add` into the execute stage, and writes `exe_result` back to the destination register. Program counter sequencing, jumps and halt are handled here.

## Interface
- `PC_W`, 8: program counter / instruction address width.
- `RESET_PC`, 0: program counter value after reset.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_req` out 1: fetch request, high while waiting for an instruction.
- `imem_addr` out PC_W: fetch address; equals PC.
- `imem_valid` in 1: `imem_data` valid this cycle.
- `imem_data` in 16: instruction word.
- `exe_a` out 16: execute operand A.
- `exe_b` out 16: execute operand B.
- `exe_add` out 1: 1 selects A+B, 0 passes B.
- `exe_result` in 16: combinational result from the execute stage.
- `halted` out 1: high once HALT has been decoded.

## Operation
- Encoding: `[15:12]` op, `[11:8]` rd, `[7:4]` rs, `[3:0]` rt, `imm8` = `[7:0]`.
- Opcodes:
  - 0x0 NOP: no effect.
  - 0x1 LDI: rd ← zero-extended `imm8`; drives `exe_b` = imm, `exe_add` = 0.
  - 0x2 ADD: rd ← R[rs] + R[rt], mod 2^16, carry discarded; drives `exe_a` = R[rs], `exe_b` = R[rt], `exe_add` = 1.
  - 0x3 MOV: rd ← R[rs]; drives `exe_b` = R[rs], `exe_add` = 0.
  - 0x4 JMP: PC ← `imm8[PC_W-1:0]`; if PC_W > 8, zero-extend.
  - 0x5 JZ: see Configuration.
  - 0xF HALT.
  - Every other opcode executes as NOP.
- All writeback data comes from `exe_result`. There is no bypass path.
- States:
  - IDLE → FETCH unconditionally.
  - FETCH: `imem_req` = 1. On `imem_valid` latch the IR and go to DECODE; otherwise stay.
  - DECODE:
    - LDI/ADD/MOV: register `exe_*`, go to EXEC.
    - JMP / JZ taken: load PC, go to FETCH.
    - NOP / JZ not taken / illegal: PC+1, go to FETCH.
    - HALT: go to HALTED.
  - EXEC: write `exe_result` into R[rd], PC+1, go to FETCH.
  - HALTED: terminal. Set `halted` = 1 and `imem_req` = 0; stay until reset.
- `exe_a`, `exe_b`, `exe_add` hold their last values outside EXEC.
- `exe_a` is unchanged by LDI and MOV.
- PC increment wraps from 2^PC_W−1 to 0.
- `imem_valid` outside FETCH is ignored.
- `imem_data` is sampled only in the cycle where FETCH and `imem_valid` are both high.

## Timing
- Reset values:
  - state IDLE
  - PC = `RESET_PC`
  - `imem_req` 0
  - `exe_a` 0, `exe_b` 0, `exe_add` 0
  - `halted` 0
  - all 16 registers 0
- Reset applies at any state, including mid-fetch with `imem_req` high. A response arriving during or after reset, before the next FETCH, is discarded.
- `imem_req` and `imem_addr` are registered; stable for the whole of FETCH.
- First `imem_req` = 1 occurs on the 2nd cycle after `rst_n` rises.
- Let N = fetch cycles, including the `imem_valid` cycle.
  - LDI/ADD/MOV: N + 2 cycles (FETCH…, DECODE, EXEC).
  - NOP/JMP/JZ: N + 1 cycles.
- Register write is visible to an instruction whose DECODE follows the writing EXEC; back-to-back dependency is always legal.
- Register file read is combinational in DECODE, using the IR latched at the end of FETCH.

## Configuration
- `FD_JZ_EN` defined: 0x5 JZ, if R[rd] == 0 then PC ← `imm8`, else PC+1. Decided in DECODE.
- `FD_JZ_EN` undefined: 0x5 decodes as NOP (PC+1) and no zero-compare logic is built.

## Structure
- Package `vdp_isa_pkg`:
  - opcode localparams `OP_NOP`, `OP_LDI`, `OP_ADD`, `OP_MOV`, `OP_JMP`, `OP_JZ`, `OP_HALT`;
  - IR field bit positions;
  - state encoding typedef `fd_state_t` (IDLE, FETCH, DECODE, EXEC, HALTED).
- Sub-module `regfile_16x16`: two combinational read ports, one synchronous write port, synchronous active-low clear.
- Execute stage is instantiated alongside by the parent, not inside this block.

## Test plan
- Reset, then `imem_valid` tied 1 → `imem_req` 0 in cycle 1, 1 in cycle 2, `imem_addr` = 0x00.
- Program LDI R1,0x05; LDI R2,0x07; ADD R3,R1,R2; MOV R4,R3 → ADD EXEC shows `exe_a` = 0x0005, `exe_b` = 0x0007, `exe_add` = 1; MOV EXEC shows `exe_b` = 0x000C, `exe_add` = 0.
- Fetch latency: hold `imem_valid` low 3 cycles per fetch → `imem_addr` stable throughout, each LDI takes 6 cycles.
- JMP 0xFF, then at 0xFF LDI R1,0x01 then NOP → next `imem_addr` wraps to 0x00.
- With `FD_JZ_EN`, R5 = 0: JZ R5,0x20 → next `imem_addr` = 0x20. With R5 = 1 → PC+1. Without the macro → always PC+1.
- HALT at 0x03 → `halted` = 1, `imem_req` stays 0 for 20 cycles. Then reset asserted mid-fetch of a later run → `imem_addr` = 0x00, registers read 0.

Source files
------------

// File: rtl/vdp_isa_pkg.sv
// ISA definitions for the VDP control core: opcodes, instruction-word field
// positions and the fetch/decode sequencer state encoding.
package vdp_isa_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int IR_OP_MSB  = 15;
  localparam int IR_OP_LSB  = 12;
  localparam int IR_RD_MSB  = 11;
  localparam int IR_RD_LSB  = 8;
  localparam int IR_RS_MSB  = 7;
  localparam int IR_RS_LSB  = 4;
  localparam int IR_RT_MSB  = 3;
  localparam int IR_RT_LSB  = 0;
  localparam int IR_IMM_MSB = 7;
  localparam int IR_IMM_LSB = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } fd_state_t;

endpackage

// File: rtl/regfile_16x16.sv
// 16 x 16-bit register file: two combinational read ports, one synchronous
// write port and a synchronous active-low clear of every entry.
module regfile_16x16 (
  input  logic        clk,
  input  logic        clr_n_i,
  input  logic [3:0]  raddr_a_i,
  output logic [15:0] rdata_a_o,
  input  logic [3:0]  raddr_b_i,
  output logic [15:0] rdata_b_o,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [15:0] wdata_i
);

  logic [15:0] mem_q [16];

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

  // Storage update: clear wins over write.
  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode sequencer of the VDP control core. Define FD_JZ_EN to build the
// conditional jump (JZ); without it opcode 0x5 behaves as NOP.
module fetch_decode
  import vdp_isa_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic [15:0]     exe_a,
  output logic [15:0]     exe_b,
  output logic            exe_add,
  input  logic [15:0]     exe_result,
  output logic            halted
);

  fd_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc_s, jmp_tgt_s;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     exe_a_q, exe_a_d, exe_b_q, exe_b_d;
  logic            exe_add_q, exe_add_d;
  logic            req_q, halted_q;
  logic [3:0]      op_s, rd_s, rs_s, rt_s, rf_raddr_a_s;
  logic [7:0]      imm_s;
  logic [15:0]     rf_a_s, rf_b_s;
  logic            rf_we_s;

  assign op_s      = ir_q[IR_OP_MSB:IR_OP_LSB];
  assign rd_s      = ir_q[IR_RD_MSB:IR_RD_LSB];
  assign rs_s      = ir_q[IR_RS_MSB:IR_RS_LSB];
  assign rt_s      = ir_q[IR_RT_MSB:IR_RT_LSB];
  assign imm_s     = ir_q[IR_IMM_MSB:IR_IMM_LSB];
  assign pc_inc_s  = pc_q + PC_W'(1'b1);
  assign jmp_tgt_s = PC_W'(imm_s);
  assign rf_we_s   = (state_q == EXEC);

`ifdef FD_JZ_EN
  logic rd_zero_s;
  // JZ tests R[rd], so port A is steered to rd only for that opcode.
  assign rf_raddr_a_s = (op_s == OP_JZ) ? rd_s : rs_s;
  assign rd_zero_s    = (rf_a_s == 16'h0000);
`else
  assign rf_raddr_a_s = rs_s;
`endif

  regfile_16x16 u_regfile (
    .clk       (clk),
    .clr_n_i   (rst_n),
    .raddr_a_i (rf_raddr_a_s),
    .rdata_a_o (rf_a_s),
    .raddr_b_i (rt_s),
    .rdata_b_o (rf_b_s),
    .we_i      (rf_we_s),
    .waddr_i   (rd_s),
    .wdata_i   (exe_result)
  );

  // Next-state, PC, IR and execute-operand selection.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    exe_a_d   = exe_a_q;
    exe_b_d   = exe_b_q;
    exe_add_d = exe_add_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        case (op_s)
          OP_LDI: begin
            exe_b_d   = {8'h00, imm_s};
            exe_add_d = 1'b0;
            state_d   = EXEC;
          end
          OP_ADD: begin
            exe_a_d   = rf_a_s;
            exe_b_d   = rf_b_s;
            exe_add_d = 1'b1;
            state_d   = EXEC;
          end
          OP_MOV: begin
            exe_b_d   = rf_a_s;
            exe_add_d = 1'b0;
            state_d   = EXEC;
          end
          OP_JMP: begin
            pc_d    = jmp_tgt_s;
            state_d = FETCH;
          end
`ifdef FD_JZ_EN
          OP_JZ: begin
            if (rd_zero_s) begin
              pc_d = jmp_tgt_s;
            end else begin
              pc_d = pc_inc_s;
            end
            state_d = FETCH;
          end
`endif
          OP_HALT: state_d = HALTED;
          default: begin
            pc_d    = pc_inc_s;
            state_d = FETCH;
          end
        endcase
      end
      EXEC: begin
        pc_d    = pc_inc_s;
        state_d = FETCH;
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered outputs; request/halt follow the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= PC_W'(RESET_PC);
      ir_q      <= 16'h0000;
      exe_a_q   <= 16'h0000;
      exe_b_q   <= 16'h0000;
      exe_add_q <= 1'b0;
      req_q     <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      exe_a_q   <= exe_a_d;
      exe_b_q   <= exe_b_d;
      exe_add_q <= exe_add_d;
      req_q     <= (state_d == FETCH);
      halted_q  <= (state_d == HALTED);
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign exe_a     = exe_a_q;
  assign exe_b     = exe_b_q;
  assign exe_add   = exe_add_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: a memory responder serves programs, a
// monitor compares fetch addresses, fetch spacing and execute operands.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] exe_a, exe_b, exe_result;
  logic        exe_add, halted;

  always #5 clk = ~clk;

  // Model of the neighbouring execute stage.
  assign exe_result = exe_add ? (exe_a + exe_b) : exe_b;

  fetch_decode #(.PC_W(8), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .exe_a      (exe_a),
    .exe_b      (exe_b),
    .exe_add    (exe_add),
    .exe_result (exe_result),
    .halted     (halted)
  );

  typedef struct {
    bit          is_exec;
    logic [7:0]  addr;
    int          gap;
    logic [15:0] a;
    logic [15:0] b;
    logic        add;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] prog [256];
  int          lat = 0;
  bit          tie = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_f(input logic [7:0] addr, input int gap);
    exp_t e;
    e.is_exec = 1'b0; e.addr = addr; e.gap = gap;
    e.a = 16'h0000; e.b = 16'h0000; e.add = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_e(input logic [15:0] a, input logic [15:0] b, input logic add);
    exp_t e;
    e.is_exec = 1'b1; e.addr = 8'h00; e.gap = 0;
    e.a = a; e.b = b; e.add = add;
    sb.push_back(e);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_cycle1", imem_req, 1'b0);
    check("rst_addr", imem_addr, 8'h00);
    check("rst_exe", {exe_a, exe_b, exe_add}, 33'h0);
    check("rst_halted", halted, 1'b0);
    @(negedge clk);
    check("rst_req_cycle2", imem_req, 1'b1);
  endtask

  task automatic wait_halt(input string name);
    int n;
    bit ok;
    n = 0;
    while (halted !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halted"}, halted, 1'b1);
    check({name, "_sb_empty"}, sb.size(), 0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || halted !== 1'b1) ok = 1'b0;
    end
    check({name, "_halt_hold"}, ok, 1'b1);
  endtask

  // Program memory: valid after `lat` wait cycles of each fetch.
  initial begin : responder
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req === 1'b1) begin
        if (cnt >= lat) begin
          imem_valid = 1'b1;
          imem_data  = prog[imem_addr];
          cnt = 0;
        end else begin
          imem_valid = 1'b0;
          cnt++;
        end
      end else begin
        imem_valid = tie;
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor: fetch starts and EXEC operand cycles.
  initial begin : monitor
    int         cyc, last_start, exec_due;
    bit         prev_req;
    logic [7:0] start_addr;
    exp_t       e;
    cyc = 0; last_start = 0; exec_due = -1; prev_req = 1'b0; start_addr = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        prev_req = 1'b0;
        exec_due = -1;
      end else begin
        if (imem_req === 1'b1 && !prev_req) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_fetch actual=%0h required=none", imem_addr);
          end else begin
            e = sb.pop_front();
            if (e.is_exec) begin
              check("order_fetch_vs_exec", imem_addr, e.b);
            end else begin
              check("fetch_addr", imem_addr, e.addr);
              if (e.gap != 0) check("fetch_cycles", cyc - last_start, e.gap);
            end
          end
          last_start = cyc;
          start_addr = imem_addr;
        end
        if (imem_req === 1'b1 && imem_valid === 1'b1) begin
          check("addr_stable", imem_addr, start_addr);
          if (imem_data[15:12] inside {4'h1, 4'h2, 4'h3}) exec_due = cyc + 2;
        end
        if (cyc == exec_due) begin
          exec_due = -1;
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_exec actual=%0h required=none", exe_b);
          end else begin
            e = sb.pop_front();
            if (!e.is_exec) check("order_exec_vs_fetch", 1'b1, 1'b0);
            else check("exec_ops", {exe_a, exe_b, exe_add}, {e.a, e.b, e.add});
          end
        end
        prev_req = (imem_req === 1'b1);
      end
    end
  end

  initial begin : stimulus
    int n;
    // ALU sequence with imem_valid tied high
    clear_prog();
    tie = 1'b1; lat = 0;
    prog[0] = 16'h1105; prog[1] = 16'h1207; prog[2] = 16'h2312; prog[3] = 16'h3430;
    push_f(8'h00, 0); push_e(16'h0000, 16'h0005, 1'b0);
    push_f(8'h01, 3); push_e(16'h0000, 16'h0007, 1'b0);
    push_f(8'h02, 3); push_e(16'h0005, 16'h0007, 1'b1);
    push_f(8'h03, 3); push_e(16'h0005, 16'h000C, 1'b0);
    push_f(8'h04, 3);
    do_reset();
    wait_halt("p1");

    // Slow memory: three wait cycles per fetch, HALT at 0x03
    clear_prog();
    tie = 1'b0; lat = 3;
    prog[0] = 16'h1111; prog[1] = 16'h1222; prog[2] = 16'h0000;
    push_f(8'h00, 0); push_e(16'h0000, 16'h0011, 1'b0);
    push_f(8'h01, 6); push_e(16'h0000, 16'h0022, 1'b0);
    push_f(8'h02, 6);
    push_f(8'h03, 5);
    do_reset();
    wait_halt("p2");

    // Jump to 0xFF and PC wrap to 0x00
    clear_prog();
    tie = 1'b0; lat = 1;
    prog[0] = 16'h40FF; prog[255] = 16'h1101;
    push_f(8'h00, 0);
    push_f(8'hFF, 3); push_e(16'h0000, 16'h0001, 1'b0);
    push_f(8'h00, 4);
    push_f(8'h01, 3);
    do_reset();
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr == 8'hFF) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("p3_reach_ff", imem_addr, 8'hFF);
    prog[0] = 16'h0000;
    wait_halt("p3");

    // Conditional jump (NOP when the feature is not built) and illegal opcode
    clear_prog();
    tie = 1'b1; lat = 0;
    prog[0] = 16'h1500; prog[1] = 16'h5520; prog[2] = 16'h4020;
    prog[32] = 16'h1501; prog[33] = 16'h5540; prog[34] = 16'h7ABC;
    push_f(8'h00, 0); push_e(16'h0000, 16'h0000, 1'b0);
    push_f(8'h01, 3);
`ifdef FD_JZ_EN
    push_f(8'h20, 2);
`else
    push_f(8'h02, 2);
    push_f(8'h20, 2);
`endif
    push_e(16'h0000, 16'h0001, 1'b0);
    push_f(8'h21, 3);
    push_f(8'h22, 2);
    push_f(8'h23, 2);
    do_reset();
    wait_halt("p4");

    // Reset in the middle of a fetch; registers must read back as zero
    clear_prog();
    tie = 1'b0; lat = 2;
    prog[0] = 16'h1133; prog[1] = 16'h1244;
    push_f(8'h00, 0); push_e(16'h0000, 16'h0033, 1'b0);
    push_f(8'h01, 5);
    do_reset();
    n = 0;
    while (!(sb.size() == 0 && imem_req === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("p5_mid_fetch", imem_addr, 8'h01);
    rst_n = 1'b0;
    tie = 1'b1; lat = 0;
    repeat (2) @(negedge clk);
    check("p5_in_reset", {imem_req, imem_addr, exe_b}, {1'b0, 8'h00, 16'h0000});
    prog[0] = 16'h2311; prog[1] = 16'hF000;
    push_f(8'h00, 0); push_e(16'h0000, 16'h0000, 1'b1);
    push_f(8'h01, 3);
    do_reset();
    wait_halt("p5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
